// File: rtl/register_file_if.sv
// rtl/register_file_if.sv - read/write port bundle for the MIPS register file
interface register_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] rs;
  logic [ADDR_WIDTH-1:0] rt;
  logic [ADDR_WIDTH-1:0] controle;
  logic [DATA_WIDTH-1:0] entrada;
  logic                  wr;
  logic [DATA_WIDTH-1:0] saidaA;
  logic [DATA_WIDTH-1:0] saidaB;

  modport master (
    output rs, rt, controle, entrada, wr,
    input  saidaA, saidaB
  );

  modport slave (
    input  rs, rt, controle, entrada, wr,
    output saidaA, saidaB
  );
endinterface

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 register file, two async read ports, one sync write port, r0 = 0
module register_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic            clock,
  input  logic            reset,
  register_file_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];

  // Per-entry address compare keeps an unknown controle from touching other entries.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (bus.wr && (bus.controle == ADDR_WIDTH'(i))) begin
          regs[i] <= bus.entrada;
        end
      end
    end
  end

  assign bus.saidaA = (bus.rs == '0) ? '0 : regs[bus.rs];
  assign bus.saidaB = (bus.rt == '0) ? '0 : regs[bus.rt];
endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed table-driven bench for register_file
module tb_register_file;
  logic clock;
  logic reset;
  int   total;
  int   passed;

  register_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual === expected) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
  endtask

  task automatic write_reg(input logic [4:0] addr, input logic [31:0] data);
    @(negedge clock);
    bus.wr       = 1'b1;
    bus.controle = addr;
    bus.entrada  = data;
    @(posedge clock);
    @(negedge clock);
    bus.wr = 1'b0;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    vecs[0] = '{5'd0, 5'd4, 32'd0,   32'd350};
    vecs[1] = '{5'd5, 5'd1, 32'd375, 32'd275};
    vecs[2] = '{5'd2, 5'd3, 32'd300, 32'd325};
    vecs[3] = '{5'd6, 5'd7, 32'd400, 32'd425};
    vecs[4] = '{5'd7, 5'd7, 32'd425, 32'd425};
    vecs[5] = '{5'd0, 5'd0, 32'd0,   32'd0};

    // Reset held with a pending write that must be lost.
    reset        = 1'b0;
    bus.wr       = 1'b1;
    bus.controle = 5'd3;
    bus.entrada  = 32'hFFFF_FFFF;
    bus.rs       = 5'd3;
    bus.rt       = 5'd31;
    repeat (2) @(posedge clock);
    #1;
    check("reset_hold_a", bus.saidaA, 32'd0);
    @(negedge clock);
    reset  = 1'b1;
    bus.wr = 1'b0;
    #1;
    check("reset_rel_a", bus.saidaA, 32'd0);
    check("reset_rel_b", bus.saidaB, 32'd0);

    // Sequential fill: controle 0..7, entrada 250 + 25*k, two cycles each.
    @(negedge clock);
    bus.wr = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.controle = 5'(k);
      bus.entrada  = 32'(250 + 25 * k);
      repeat (2) @(negedge clock);
    end
    bus.wr = 1'b0;

    for (int v = 0; v < 6; v++) begin
      bus.rs = vecs[v].rs;
      bus.rt = vecs[v].rt;
      #1;
      check($sformatf("fill_a[%0d]", v), bus.saidaA, vecs[v].exp_a);
      check($sformatf("fill_b[%0d]", v), bus.saidaB, vecs[v].exp_b);
    end

    // r0 protection
    write_reg(5'd0, 32'hDEAD_BEEF);
    bus.rs = 5'd0;
    bus.rt = 5'd0;
    #1;
    check("r0_a", bus.saidaA, 32'd0);
    check("r0_b", bus.saidaB, 32'd0);
    bus.rt = 5'd1;
    #1;
    check("r0_r1_intact", bus.saidaB, 32'd275);

    // Write disable
    write_reg(5'd9, 32'd500);
    bus.controle = 5'd9;
    bus.entrada  = 32'd777;
    bus.rt       = 5'd9;
    repeat (3) @(posedge clock);
    #1;
    check("wr_disable", bus.saidaB, 32'd500);

    // Read-during-write on the same address
    write_reg(5'd8, 32'd450);
    bus.rs       = 5'd8;
    bus.rt       = 5'd9;
    bus.wr       = 1'b1;
    bus.controle = 5'd8;
    bus.entrada  = 32'd475;
    #1;
    check("rdw_before", bus.saidaA, 32'd450);
    @(posedge clock);
    #1;
    check("rdw_after", bus.saidaA, 32'd475);
    check("rdw_other", bus.saidaB, 32'd500);
    @(negedge clock);
    bus.wr = 1'b0;

    // Asynchronous reset pulse between edges
    #2;
    reset = 1'b0;
    #1;
    check("async_a", bus.saidaA, 32'd0);
    check("async_b", bus.saidaB, 32'd0);
    #1;
    reset = 1'b1;
    for (int r = 1; r < 10; r++) begin
      bus.rs = 5'(r);
      #1;
      check($sformatf("post_reset_r%0d", r), bus.saidaA, 32'd0);
    end

    // Writes resume after reset release
    write_reg(5'd5, 32'h0000_1234);
    bus.rs = 5'd5;
    bus.rt = 5'd5;
    #1;
    check("resume_a", bus.saidaA, 32'h0000_1234);
    check("resume_b", bus.saidaB, 32'h0000_1234);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
